// File: rtl/medidor_frequencia.sv
// Period meter: counts clk cycles between rising edges of a slow asynchronous input.
// Optional glitch filter on the synchronized input is enabled by defining MEDIDOR_FILTRO_EN.
module medidor_frequencia #(
   parameter int CNT_W      = 32,
   parameter int MAX_PERIOD = 100_000_000,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] periodo,
   output logic             valido,
   output logic             timeout,
   output logic             ativo
);

   typedef enum logic [1:0] {OCIOSO, MEDINDO, ESTOURO} estado_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] UM      = CNT_W'(1);

   if (DEB_CYCLES < 1 || longint'(MAX_PERIOD) >= (longint'(1) << CNT_W)) begin : g_param_check
      $error("medidor_frequencia: DEB_CYCLES must be >= 1 and MAX_PERIOD < 2**CNT_W");
   end

   logic             sync_p0, sync_p1;
   logic             nivel, hist;
   logic             borda;
   estado_t          estado, estado_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, periodo_nxt;
   logic             valido_nxt;

   // stage 0/1: two-flop synchronizer for the asynchronous input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= sig_in;
         sync_p1 <= sync_p0;
      end
   end

`ifdef MEDIDOR_FILTRO_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   logic [DEB_W-1:0] deb_cnt;

   // filter stage: level follows the input only after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nivel   <= 1'b0;
         deb_cnt <= '0;
      end else if (sync_p1 == nivel) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
         nivel   <= sync_p1;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + DEB_W'(1);
      end
   end
`else
   assign nivel = sync_p1;
`endif

   // stage 2: history flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hist <= 1'b0;
      else      hist <= nivel;
   end

   assign borda = nivel & ~hist;

   always_comb begin
      estado_nxt  = estado;
      cnt_nxt     = cnt;
      periodo_nxt = periodo;
      valido_nxt  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (borda) begin
               estado_nxt = MEDINDO;
               cnt_nxt    = UM;
            end
         end
         MEDINDO: begin
            // an edge coinciding with the limit still counts as a valid period
            if (borda) begin
               periodo_nxt = cnt;
               valido_nxt  = 1'b1;
               cnt_nxt     = UM;
            end else if (cnt == MAX_CNT) begin
               estado_nxt  = ESTOURO;
               periodo_nxt = '0;
            end else begin
               cnt_nxt = cnt + UM;
            end
         end
         ESTOURO: begin
            if (borda) begin
               estado_nxt = MEDINDO;
               cnt_nxt    = UM;
            end
         end
         default: estado_nxt = OCIOSO;
      endcase
   end

   // stage 3: state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado  <= OCIOSO;
         cnt     <= '0;
         periodo <= '0;
         valido  <= 1'b0;
         timeout <= 1'b0;
         ativo   <= 1'b0;
      end else begin
         estado  <= estado_nxt;
         cnt     <= cnt_nxt;
         periodo <= periodo_nxt;
         valido  <= valido_nxt;
         timeout <= (estado_nxt == ESTOURO);
         ativo   <= (estado_nxt == MEDINDO);
      end
   end

endmodule

// File: tb/tb_medidor_frequencia.sv
// Self-checking bench for medidor_frequencia: random and directed waveforms against an edge/interval model.
module tb_medidor_frequencia;

   localparam int CNT_W = 32;
   localparam int MAXP  = 50;
   localparam int DEB   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] periodo;
   logic             valido, timeout, ativo;

   always #5 clk = ~clk;

   medidor_frequencia #(
      .CNT_W     (CNT_W),
      .MAX_PERIOD(MAXP),
      .DEB_CYCLES(DEB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .periodo(periodo),
      .valido (valido),
      .timeout(timeout),
      .ativo  (ativo)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // behavioural model: sampled input history -> edge times -> intervals
   typedef enum int {M_IDLE, M_MEAS, M_TOUT} mstate_t;
   mstate_t          m_st;
   int               cyc;
   int               m_last;
   logic [CNT_W-1:0] m_per;
   bit               m_vld;
   bit               xh[16];
   bit               yh[2];

   logic [CNT_W-1:0] last_per, first_per;
   int               n_vld;

   function automatic void model_reset();
      m_st  = M_IDLE;
      m_per = '0;
      m_vld = 1'b0;
      for (int i = 0; i < 16; i++) xh[i] = 1'b0;
      yh[0] = 1'b0;
      yh[1] = 1'b0;
   endfunction

   function automatic void model_step(input bit x);
      bit edge_now;
      bit y;
      cyc++;
      for (int i = 15; i > 0; i--) xh[i] = xh[i-1];
      xh[0] = x;
      edge_now = yh[0] & ~yh[1];
`ifdef MEDIDOR_FILTRO_EN
      begin
         bit all_new;
         all_new = 1'b1;
         for (int i = 2; i <= DEB + 1; i++) if (xh[i] == yh[0]) all_new = 1'b0;
         y = all_new ? ~yh[0] : yh[0];
      end
`else
      y = xh[1];
`endif
      yh[1] = yh[0];
      yh[0] = y;
      m_vld = 1'b0;
      case (m_st)
         M_IDLE: if (edge_now) begin m_st = M_MEAS; m_last = cyc; end
         M_MEAS: begin
            if (edge_now) begin
               m_vld  = 1'b1;
               m_per  = CNT_W'(cyc - m_last);
               m_last = cyc;
            end else if (cyc - m_last == MAXP) begin
               m_st  = M_TOUT;
               m_per = '0;
            end
         end
         default: if (edge_now) begin m_st = M_MEAS; m_last = cyc; end
      endcase
   endfunction

   function automatic logic [63:0] model_outs();
      return {29'b0, m_vld, (m_st == M_TOUT), (m_st == M_MEAS), m_per};
   endfunction

   task automatic tick_r(input bit v, input bit r);
      @(negedge clk);
      sig_in = v;
      rst    = r;
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step(v);
      #1;
      check("outs", {29'b0, valido, timeout, ativo, periodo}, model_outs());
      if (valido) begin
         if (n_vld == 0) first_per = periodo;
         last_per = periodo;
         n_vld++;
      end
   endtask

   task automatic tick(input bit v);
      tick_r(v, rst);
   endtask

   task automatic wave(input int p, input int n, input int hi);
      for (int k = 0; k < n; k++)
         for (int c = 0; c < p; c++) tick(c < hi);
   endtask

   task automatic async_reset(input int d);
      #d rst = 1'b0;
      model_reset();
      #1 check("async_rst", {29'b0, valido, timeout, ativo, periodo}, model_outs());
      tick_r(1'b0, 1'b0);
      tick_r(1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      cyc = 0;
      m_last = 0;
      n_vld = 0;
      last_per = '0;
      first_per = '0;
      model_reset();
      #2 rst = 1'b0;
      #1 check("reset_state", {29'b0, valido, timeout, ativo, periodo}, 64'd0);
      repeat (3) tick(1'b0);
      tick_r(1'b0, 1'b1);

      // period 10: first edge is reference only
      n_vld = 0;
      wave(10, 6, 5);
      check("p10_last", last_per, 10);
      check("p10_count", n_vld, 5);

      // change to 37: no intermediate value
      n_vld = 0;
      repeat (27) tick(1'b0);
      wave(37, 3, 18);
      check("p37_first", first_per, 37);
      check("p37_last", last_per, 37);
      check("p37_count", n_vld, 3);

      // minimum period
      wave(2, 8, 1);
      check("p2_last", last_per, 2);

      // timeout after the input stays low
      repeat (60) tick(1'b0);
      check("tout_level", timeout, 1);
      check("tout_per", periodo, 0);
      n_vld = 0;
      tick(1'b1);
      repeat (19) tick(1'b0);
      check("tout_clear", timeout, 0);
      tick(1'b1);
      repeat (5) tick(1'b0);
      check("after_tout_count", n_vld, 1);
      check("after_tout_per", last_per, 20);

      // edge exactly at the limit, then just beyond it
      wave(50, 3, 25);
      check("pmax_last", last_per, MAXP);
      check("pmax_tout", timeout, 0);
      wave(51, 2, 25);
      repeat (5) tick(1'b0);
      check("p51_tout", timeout, 1);

      // asynchronous reset mid-measurement
      wave(13, 3, 6);
      tick(1'b1);
      repeat (5) tick(1'b0);
      n_vld = 0;
      async_reset(2);
      check("rst_mid_per", periodo, 0);
      wave(13, 3, 6);
      check("rst_after_count", n_vld, 2);
      check("rst_after_first", first_per, 13);

`ifdef MEDIDOR_FILTRO_EN
      // narrow glitches inside both halves of a period-40 wave
      wave(40, 2, 20);
      for (int k = 0; k < 3; k++) begin
         repeat (8)  tick(1'b1);
         repeat (2)  tick(1'b0);
         repeat (10) tick(1'b1);
         repeat (8)  tick(1'b0);
         repeat (2)  tick(1'b1);
         repeat (10) tick(1'b0);
      end
      check("filt_p40", last_per, 40);
`endif

      // randomized periods, duties and occasional asynchronous resets
      for (int it = 0; it < 25; it++) begin
         int p, n, hi;
         p  = $urandom_range(2, 60);
         n  = $urandom_range(1, 3);
         hi = $urandom_range(1, p - 1);
         wave(p, n, hi);
         if ($urandom_range(0, 7) == 0) async_reset($urandom_range(1, 3));
      end
      repeat (4) tick(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
